// File: rtl/fc_pkg.sv
// Shared types and Q16.16 arithmetic for the fully-connected backward engine.
package fc_pkg;

  localparam int Q_FRAC = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    DB,
    DW,
    DX,
    DONE
  } fc_bwd_state_e;

  // Counter width for an index running 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed Q16.16 product: full 64-bit product, arithmetic shift, keep 32 bits.
  function automatic logic [WORD_W-1:0] q_mul(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b);
    logic signed [2*WORD_W-1:0] p;
    p = $signed({{WORD_W{a[WORD_W-1]}}, a}) * $signed({{WORD_W{b[WORD_W-1]}}, b});
    return p[Q_FRAC +: WORD_W];
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Serial multiply-accumulate with a registered accumulator; the running sum
// including the current term is exposed combinationally so the last step can be stored.
module fc_mac
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              bypass_mul_i,
  input  logic              clear_i,
  input  logic              en_i,
  output logic [WORD_W-1:0] acc_next_o
);

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] term;

  assign term       = bypass_mul_i ? a_i : q_mul(a_i, b_i);
  assign acc_next_o = acc_q + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= clear_i ? '0 : acc_next_o;
    end
  end

endmodule

// File: rtl/fully_connect_backward.sv
// Backward pass of a fully-connected layer (bias, weight and input gradients)
// computed one MAC per cycle from a snapshot of dy/data/weight taken at accept.
//
// state | meaning
// IDLE  | waiting for start; gradients held
// DB    | grad_bias:   o outer, b inner, multiplier bypassed
// DW    | grad_weight: f, o outer, b inner
// DX    | grad_data:   b, f outer, o inner
// DONE  | one-cycle done pulse, then back to IDLE
module fully_connect_backward
  import fc_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int FEATURE_SIZE = 3,
  parameter int BIAS_SIZE    = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start_i,
  input  logic [BATCH_SIZE*BIAS_SIZE*WORD_W-1:0]     dy_i,
  input  logic [BATCH_SIZE*FEATURE_SIZE*WORD_W-1:0]  data_i,
  input  logic [FEATURE_SIZE*BIAS_SIZE*WORD_W-1:0]   weight_i,
  output logic [FEATURE_SIZE*BIAS_SIZE*WORD_W-1:0]   grad_weight_o,
  output logic [BIAS_SIZE*WORD_W-1:0]                grad_bias_o,
  output logic [BATCH_SIZE*FEATURE_SIZE*WORD_W-1:0]  grad_data_o,
  output logic                                       busy_o,
  output logic                                       done_o
);

  localparam int B   = BATCH_SIZE;
  localparam int F   = FEATURE_SIZE;
  localparam int O   = BIAS_SIZE;
  localparam int NDY = B * O;
  localparam int NDA = B * F;
  localparam int NW  = F * O;
  localparam int BW  = idx_w(B);
  localparam int FW  = idx_w(F);
  localparam int OW  = idx_w(O);
  localparam int DYW = idx_w(NDY);
  localparam int DAW = idx_w(NDA);
  localparam int WW  = idx_w(NW);
  localparam logic [BW-1:0] B_LAST = BW'(B - 1);
  localparam logic [FW-1:0] F_LAST = FW'(F - 1);
  localparam logic [OW-1:0] O_LAST = OW'(O - 1);

  fc_bwd_state_e state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [FW-1:0] f_q, f_d;
  logic [OW-1:0] o_q, o_d;

  logic [WORD_W-1:0] dy_q     [NDY];
  logic [WORD_W-1:0] data_q   [NDA];
  logic [WORD_W-1:0] weight_q [NW];
  logic [WORD_W-1:0] gw_q     [NW];
  logic [WORD_W-1:0] gb_q     [O];
  logic [WORD_W-1:0] gd_q     [NDA];

  logic [DYW-1:0] dy_idx;
  logic [DAW-1:0] data_idx;
  logic [WW-1:0]  w_idx;

  logic              accept;
  logic              mac_en, mac_bypass, mac_last;
  logic [WORD_W-1:0] mac_a, mac_b, acc_next;

  assign accept   = (state_q == IDLE) && start_i;
  assign dy_idx   = DYW'(int'(b_q) * O + int'(o_q));
  assign data_idx = DAW'(int'(b_q) * F + int'(f_q));
  assign w_idx    = WW'(int'(f_q) * O + int'(o_q));

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    f_d        = f_q;
    o_d        = o_q;
    mac_en     = 1'b0;
    mac_bypass = 1'b0;
    mac_last   = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = DB;
          b_d     = '0;
          f_d     = '0;
          o_d     = '0;
        end
      end
      DB: begin
        mac_en     = 1'b1;
        mac_bypass = 1'b1;
        mac_a      = dy_q[dy_idx];
        mac_last   = (b_q == B_LAST);
        if (b_q == B_LAST) begin
          b_d = '0;
          if (o_q == O_LAST) begin
            o_d     = '0;
            state_d = DW;
          end else begin
            o_d = o_q + 1'b1;
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DW: begin
        mac_en   = 1'b1;
        mac_a    = data_q[data_idx];
        mac_b    = dy_q[dy_idx];
        mac_last = (b_q == B_LAST);
        if (b_q == B_LAST) begin
          b_d = '0;
          if (o_q == O_LAST) begin
            o_d = '0;
            if (f_q == F_LAST) begin
              f_d     = '0;
              state_d = DX;
            end else begin
              f_d = f_q + 1'b1;
            end
          end else begin
            o_d = o_q + 1'b1;
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DX: begin
        mac_en   = 1'b1;
        mac_a    = dy_q[dy_idx];
        mac_b    = weight_q[w_idx];
        mac_last = (o_q == O_LAST);
        if (o_q == O_LAST) begin
          o_d = '0;
          if (f_q == F_LAST) begin
            f_d = '0;
            if (b_q == B_LAST) begin
              b_d     = '0;
              state_d = DONE;
            end else begin
              b_d = b_q + 1'b1;
            end
          end else begin
            f_d = f_q + 1'b1;
          end
        end else begin
          o_d = o_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      f_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      f_q     <= f_d;
      o_q     <= o_d;
    end
  end

  // Input snapshot at accept and progressive gradient writes at each last inner step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDY; i++) dy_q[i] <= '0;
      for (int i = 0; i < NDA; i++) begin
        data_q[i] <= '0;
        gd_q[i]   <= '0;
      end
      for (int i = 0; i < NW; i++) begin
        weight_q[i] <= '0;
        gw_q[i]     <= '0;
      end
      for (int i = 0; i < O; i++) gb_q[i] <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NDY; i++) dy_q[i]     <= dy_i[i*WORD_W +: WORD_W];
        for (int i = 0; i < NDA; i++) data_q[i]   <= data_i[i*WORD_W +: WORD_W];
        for (int i = 0; i < NW; i++)  weight_q[i] <= weight_i[i*WORD_W +: WORD_W];
      end
      if (mac_last) begin
        unique case (state_q)
          DB:      gb_q[o_q]      <= acc_next;
          DW:      gw_q[w_idx]    <= acc_next;
          DX:      gd_q[data_idx] <= acc_next;
          default: ;
        endcase
      end
    end
  end

  fc_mac u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_i          (mac_a),
    .b_i          (mac_b),
    .bypass_mul_i (mac_bypass),
    .clear_i      (mac_last),
    .en_i         (mac_en),
    .acc_next_o   (acc_next)
  );

  for (genvar i = 0; i < NW; i++) begin : g_gw
    assign grad_weight_o[i*WORD_W +: WORD_W] = gw_q[i];
  end
  for (genvar i = 0; i < O; i++) begin : g_gb
    assign grad_bias_o[i*WORD_W +: WORD_W] = gb_q[i];
  end
  for (genvar i = 0; i < NDA; i++) begin : g_gd
    assign grad_data_o[i*WORD_W +: WORD_W] = gd_q[i];
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_fully_connect_backward.sv
// Directed bench: default 1x3x2 instance driven from a vector table plus
// hand-written sequences, and a 2x2x2 instance for the batched case.
module tb_fully_connect_backward;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] P1 = 32'h0001_0000;
  localparam logic [31:0] P2 = 32'h0002_0000;
  localparam logic [31:0] P3 = 32'h0003_0000;
  localparam logic [31:0] M1 = 32'hFFFF_0000;
  localparam logic [31:0] M2 = 32'hFFFE_0000;
  localparam logic [31:0] M3 = 32'hFFFD_0000;

  logic         rst_n;
  logic         start1, busy1, done1;
  logic [63:0]  dy1, gb1;
  logic [95:0]  data1, gd1;
  logic [191:0] w1, gw1;

  logic         start2, busy2, done2;
  logic [127:0] dy2, data2, w2, gw2, gd2;
  logic [63:0]  gb2;

  int n_checks = 0;
  int n_errors = 0;

  fully_connect_backward dut (
    .clk(clk), .rst_n(rst_n), .start_i(start1),
    .dy_i(dy1), .data_i(data1), .weight_i(w1),
    .grad_weight_o(gw1), .grad_bias_o(gb1), .grad_data_o(gd1),
    .busy_o(busy1), .done_o(done1)
  );

  fully_connect_backward #(.BATCH_SIZE(2), .FEATURE_SIZE(2), .BIAS_SIZE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2),
    .dy_i(dy2), .data_i(data2), .weight_i(w2),
    .grad_weight_o(gw2), .grad_bias_o(gb2), .grad_data_o(gd2),
    .busy_o(busy2), .done_o(done2)
  );

  typedef struct packed {
    logic [95:0]  data;
    logic [63:0]  dy;
    logic [191:0] w;
    logic [63:0]  gb;
    logic [191:0] gw;
    logic [95:0]  gd;
  } vec_t;

  vec_t vecs [3];

  function automatic logic [63:0] pk2(input logic [31:0] a, input logic [31:0] b);
    return {b, a};
  endfunction
  function automatic logic [95:0] pk3(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return {c, b, a};
  endfunction
  function automatic logic [191:0] pk6(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d,
                                       input logic [31:0] e, input logic [31:0] f);
    return {f, e, d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call right after the accept edge; returns cycles from accept to done.
  task automatic wait_done1(output int lat);
    lat = 0;
    @(negedge clk);
    while (!done1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start1_now(input logic [95:0] d, input logic [63:0] y, input logic [191:0] w);
    @(negedge clk);
    data1  = d;
    dy1    = y;
    w1     = w;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    chk("busy_after_accept", 256'(busy1), 256'(1'b1));
  endtask

  task automatic chk_out1(input string tag, input vec_t v);
    chk({tag, "_grad_bias"},   256'(gb1), 256'(v.gb));
    chk({tag, "_grad_weight"}, 256'(gw1), 256'(v.gw));
    chk({tag, "_grad_data"},   256'(gd1), 256'(v.gd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   n_done;
    int   done_at [4];
    int   dcount;
    vec_t neg;

    vecs[0] = '{data: pk3(P1, P2, P3), dy: pk2(P1, M1), w: pk6(P1, Z, Z, P1, P2, P2),
                gb: pk2(P1, M1), gw: pk6(P1, M1, P2, M2, P3, M3), gd: pk3(P1, M1, Z)};
    vecs[1] = '{data: pk3(32'h7FFF_0000, Z, Z), dy: pk2(P2, Z), w: pk6(P1, Z, Z, P1, P2, P2),
                gb: pk2(P2, Z), gw: pk6(32'hFFFE_0000, Z, Z, Z, Z, Z),
                gd: pk3(P2, Z, 32'h0004_0000)};
    vecs[2] = '{data: pk3(32'h0000_8000, 32'hFFFE_8000, 32'h0000_4000),
                dy: pk2(P2, 32'h0000_8000), w: pk6(P1, Z, Z, P1, P2, P2),
                gb: pk2(P2, 32'h0000_8000),
                gw: pk6(P1, 32'h0000_4000, M3, 32'hFFFF_4000, 32'h0000_8000, 32'h0000_2000),
                gd: pk3(P2, 32'h0000_8000, 32'h0005_0000)};
    neg = '{data: pk3(P1, P2, P3), dy: pk2(M1, P1), w: pk6(P1, Z, Z, P1, P2, P2),
            gb: pk2(M1, P1), gw: pk6(M1, P1, M2, P2, M3, P3), gd: pk3(M1, P1, Z)};

    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    dy1 = '0; data1 = '0; w1 = '0;
    dy2 = '0; data2 = '0; w2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 256'(busy1), 256'(1'b0));
    chk("reset_done", 256'(done1), 256'(1'b0));
    chk("reset_grads", 256'({gb1, gw1, gd1}), 256'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      start1_now(vecs[i].data, vecs[i].dy, vecs[i].w);
      wait_done1(lat);
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(14));
      chk_out1($sformatf("vec%0d", i), vecs[i]);
    end

    // start held for 20 cycles; inputs scrambled after the first accept
    n_done = 0;
    @(negedge clk);
    data1 = vecs[0].data; dy1 = vecs[0].dy; w1 = vecs[0].w;
    start1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        data1 = {3{32'h0005_0000}};
        dy1   = {2{32'h0007_0000}};
        w1    = '0;
      end
      if (c == 15) begin
        data1 = vecs[0].data; dy1 = vecs[0].dy; w1 = vecs[0].w;
      end
      if (c == 19) start1 = 1'b0;
      @(negedge clk);
      if (done1) begin
        if (n_done < 4) done_at[n_done] = c;
        n_done++;
        chk_out1("held_start", vecs[0]);
      end
    end
    chk("held_start_done_count", 256'(n_done), 256'(2));
    chk("held_start_first_done", 256'(done_at[0]), 256'(14));
    chk("held_start_second_done", 256'(done_at[1]), 256'(30));

    // asynchronous reset in the middle of a run
    start1_now(vecs[0].data, vecs[0].dy, vecs[0].w);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 256'(busy1), 256'(1'b0));
    chk("midreset_done", 256'(done1), 256'(1'b0));
    chk("midreset_grads", 256'({gb1, gw1, gd1}), 256'(0));
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done1) dcount++;
    end
    chk("midreset_no_done", 256'(dcount), 256'(0));
    start1_now(vecs[0].data, vecs[0].dy, vecs[0].w);
    wait_done1(lat);
    chk("after_reset_latency", 256'(lat), 256'(14));
    chk_out1("after_reset", vecs[0]);

    // back-to-back run with dy negated, start raised in the done cycle
    dy1    = neg.dy;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_busy", 256'(busy1), 256'(1'b0));
    chk("b2b_idle_done", 256'(done1), 256'(1'b0));
    chk_out1("b2b_held", vecs[0]);
    @(posedge clk);
    #1 start1 = 1'b0;
    chk("b2b_busy", 256'(busy1), 256'(1'b1));
    chk_out1("b2b_at_accept", vecs[0]);
    wait_done1(lat);
    chk("b2b_latency", 256'(lat), 256'(14));
    chk_out1("b2b_negated", neg);

    // batched instance, B=F=O=2
    @(negedge clk);
    dy2    = {P2, P2, P1, P1};
    data2  = {P1, Z, Z, P1};
    w2     = {P1, Z, Z, P1};
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!done2 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("b2_latency", 256'(lat), 256'(20));
    chk("b2_grad_bias", 256'(gb2), 256'({P3, P3}));
    chk("b2_grad_weight", 256'(gw2), 256'({P2, P2, P1, P1}));
    chk("b2_grad_data", 256'(gd2), 256'({P2, P2, P1, P1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
